// File: rtl/leglite_pkg.sv
// Types and constants shared by the LEGLite fetch, decode and execute blocks.
package leglite_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_ADD  = 4'd0;
  localparam opcode_t OP_LDUR = 4'd5;
  localparam opcode_t OP_STUR = 4'd6;
  localparam opcode_t OP_CBZ  = 4'd7;
  localparam opcode_t OP_ADDI = 4'd8;
  localparam opcode_t OP_ANDI = 4'd9;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/leglite_next_pc.sv
// Next-PC selection for the fetch unit: a taken branch beats sequential
// advance, which beats holding the current PC.
module leglite_next_pc #(
  parameter int PC_WIDTH = 16
) (
  input  logic                resolve_valid,
  input  logic                branch,
  input  logic                uncondbranch,
  input  logic                zero,
  input  logic [PC_WIDTH-1:0] resolve_pc,
  input  logic [PC_WIDTH-1:0] resolve_offset,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] instr_pc,
  input  logic                advance,
  output logic                take,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] target;

  always_comb begin
    take   = resolve_valid & (uncondbranch | (branch & zero));
    // Offset is already sign-extended, so plain modular addition suffices.
    target = resolve_pc + resolve_offset;
    if (take) begin
      next_pc = target;
    end else if (advance) begin
      next_pc = instr_pc + PC_WIDTH'(1);
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/leglite_fetch.sv
// LEGLite instruction fetch: owns the PC, issues one imem read at a time and
// hands instructions downstream, squashing wrong-path fetches on redirect.
module leglite_fetch
  import leglite_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output opcode_t                opcode,
  output logic [PC_WIDTH-1:0]    instr_pc,
  input  logic                   instr_accept,
  input  logic                   resolve_valid,
  input  logic                   branch,
  input  logic                   uncondbranch,
  input  logic                   zero,
  input  logic [PC_WIDTH-1:0]    resolve_pc,
  input  logic [PC_WIDTH-1:0]    resolve_offset
);

  fetch_state_t           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   req_q, req_d;
  logic [PC_WIDTH-1:0]    req_addr_q, req_addr_d;
  logic                   valid_q, valid_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    instr_pc_q, instr_pc_d;

  logic                   take;
  logic                   advance;
  logic [PC_WIDTH-1:0]    next_pc;

  assign advance = (state_q == HOLD) & instr_accept;

  leglite_next_pc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_next_pc (
    .resolve_valid (resolve_valid),
    .branch        (branch),
    .uncondbranch  (uncondbranch),
    .zero          (zero),
    .resolve_pc    (resolve_pc),
    .resolve_offset(resolve_offset),
    .pc            (pc_q),
    .instr_pc      (instr_pc_q),
    .advance       (advance),
    .take          (take),
    .next_pc       (next_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = next_pc;
    req_d      = req_q;
    req_addr_d = req_addr_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      RESET: begin
        pc_d       = pc_q;
        state_d    = FETCH;
        req_d      = 1'b1;
        req_addr_d = pc_q;
      end
      FETCH: begin
        if (take) begin
          // A response arriving with the redirect is wrong-path; drop it.
          if (imem_ready) begin
            req_addr_d = next_pc;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ready) begin
          state_d    = HOLD;
          req_d      = 1'b0;
          valid_d    = 1'b1;
          instr_d    = imem_data;
          instr_pc_d = req_addr_q;
        end
      end
      HOLD: begin
        if (take || instr_accept) begin
          state_d    = FETCH;
          req_d      = 1'b1;
          req_addr_d = next_pc;
          valid_d    = 1'b0;
        end
      end
      DRAIN: begin
        if (imem_ready) begin
          state_d    = FETCH;
          req_addr_d = next_pc;
        end
      end
      default: begin
        state_d = RESET;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RESET;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= '0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = req_addr_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[INSTR_WIDTH-1 -: 4];
  assign instr_pc    = instr_pc_q;

endmodule

// File: doc/leglite_fetch.md
# leglite_fetch

Instruction fetch unit for LEGLite. It owns the program counter and issues one instruction-memory read at a time. It presents each fetched 16-bit instruction and its 4-bit opcode to the Control decoder and datapath through a valid/accept handshake. It takes branch resolution from the execute stage (Control's `branch`/`uncondbranch` plus the ALU `zero` flag) and redirects the PC, discarding any wrong-path fetch.

## Interface
- `PC_WIDTH`, 16, instruction-memory word address width; the PC counts words.
- `INSTR_WIDTH`, 16, instruction width; opcode is `instr[INSTR_WIDTH-1 -: 4]`.
- `RESET_PC`, 0, PC value loaded on reset.
- `clock`  in  1  sole clock; everything updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  read request, held until `imem_ready`.
- `imem_addr`  out  PC_WIDTH  read address, stable while `imem_req`=1.
- `imem_ready`  in  1  `imem_data` valid for the held address this cycle.
- `imem_data`  in  INSTR_WIDTH  read data.
- `instr_valid`  out  1  `instr`/`opcode`/`instr_pc` valid.
- `instr`  out  INSTR_WIDTH  fetched instruction.
- `opcode`  out  4  `instr[15:12]`, wired to Control `opcode`.
- `instr_pc`  out  PC_WIDTH  address of `instr`.
- `instr_accept`  in  1  downstream consumes `instr` this cycle.
- `resolve_valid`  in  1  a branch-class instruction resolves this cycle.
- `branch`, `uncondbranch`, `zero`  in  1 each  Control/ALU outputs for the resolving instruction.
- `resolve_pc`  in  PC_WIDTH  PC of the resolving instruction.
- `resolve_offset`  in  PC_WIDTH  signed word offset, already sign-extended.

## Operation
- Taken condition: `take = resolve_valid & (uncondbranch | (branch & zero))`.
- Branch target: `resolve_pc + resolve_offset`, modulo 2^PC_WIDTH.
- Sequential PC: `pc + 1`, which wraps from all-ones to 0.
- FSM has four states: RESET, FETCH, HOLD, DRAIN.
- RESET:
  - This state is entered whenever `reset_n`=0.
  - It sets `pc`=RESET_PC and drives all outputs to 0.
  - It moves to FETCH on the first cycle with `reset_n`=1.
- FETCH:
  - Drives `imem_req`=1 and `imem_addr`=`pc`; the address is latched in `req_addr`.
  - On `imem_ready`, it captures the data into `instr`, sets `instr_pc`=`req_addr`, and moves to HOLD.
- HOLD:
  - Drives `instr_valid`=1; `instr` is held stable.
  - On `instr_accept`, it sets `pc`=`instr_pc`+1 and moves to FETCH.
- Redirect (`take`=1) has priority over accept and capture in every non-RESET state. It sets `pc`=target on that edge and clears `instr_valid` the next cycle.
  - In HOLD or FETCH with `imem_ready`=1: the data is discarded and the FSM goes to FETCH.
  - In FETCH with `imem_ready`=0: the FSM goes to DRAIN.
- DRAIN:
  - Keeps `imem_req`=1 and `imem_addr`=`req_addr` (the stale address).
  - On `imem_ready`, it discards the data and moves to FETCH with the new `pc`.
  - A further `take` in DRAIN only updates `pc`.
- A not-taken resolve has no effect.
- Only one request is outstanding at any time. The memory may return `imem_ready` in the same cycle as the request (zero wait).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `opcode`=0, `instr_pc`=0, `pc`=RESET_PC.
- First `imem_req`: the cycle after `reset_n` is released.
- Zero-wait memory: one instruction every 2 cycles (FETCH, HOLD) with `instr_accept` tied high.
- Latency: `instr_valid` rises 1 cycle after the `imem_ready` edge.
- Redirect: the first wrong-path-free request is issued the cycle after `take` (HOLD case), or the cycle after the stale `imem_ready` (DRAIN case).
- Reset asserted mid-FETCH or mid-DRAIN: `imem_req` drops on that edge and the outstanding response is ignored. The memory side must tolerate an abandoned request.
- `instr_accept` while `instr_valid`=0 is ignored.

## Structure
- Shared package `leglite_pkg` holds:
  - `opcode_t` (4-bit).
  - Opcode constants: OP_ADD=0, OP_LDUR=5, OP_STUR=6, OP_CBZ=7, OP_ADDI=8, OP_ANDI=9.
  - `fetch_state_t` enum {RESET, FETCH, HOLD, DRAIN}.
- Sub-module `leglite_next_pc` (combinational) computes `take` and the next PC: sequential, branch target, or hold.
- The FSM and registers stay in `leglite_fetch`.

## Test plan
- Reset and sequential fetch:
  - Stimulus: `reset_n` low for 3 cycles, then high; zero-wait memory with mem[i]=16'h0000+i; `instr_accept`=1.
  - Response: `imem_req` rises 1 cycle after release; addresses 0,1,2,3 appear; `instr_pc`/`instr` pairs (0,0x0000), (1,0x0001)… one every 2 cycles.
- Wait states and backpressure:
  - Stimulus: 3-cycle memory latency; `instr_accept` held low for 4 cycles.
  - Response: `imem_addr` stable for 3 cycles; `instr` stable while `instr_valid`=1 and not accepted; no new request until accept.
- Taken CBZ in HOLD:
  - Stimulus: instr 16'h7xxx at pc 4; `resolve_valid`=1, `branch`=1, `zero`=1, `resolve_pc`=4, `resolve_offset`=-3.
  - Response: next request address 1; `instr_valid` low the cycle after.
- Not-taken CBZ:
  - Stimulus: same as the taken case but with `zero`=0.
  - Response: fetch continues at 5.
- Redirect during FETCH:
  - Stimulus: `uncondbranch`=1 with target 0x20 while waiting on address 9; response returns 2 cycles later.
  - Response: state goes to DRAIN with `imem_addr`=9 held; data for address 9 is never presented; the next request is 0x20.
- Wrap-around and reset mid-operation:
  - Stimulus (wrap): `pc`=16'hFFFF is accepted.
  - Response (wrap): next address is 0.
  - Stimulus (reset): `reset_n` pulled low while in DRAIN.
  - Response (reset): all outputs are 0 the next cycle and fetch restarts at RESET_PC.
